// File: rtl/jtopl_i2s_tx.sv
// rtl/jtopl_i2s_tx.sv - mono sample FIFO feeding an I2S stereo serialiser
module jtopl_i2s_tx #(
  parameter int W   = 16,
  parameter int DIV = 4,
  parameter int AW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  sample,
  input  logic          sample_vld,
  input  logic          mute,
  input  logic          clr,
  output logic          sck,
  output logic          ws,
  output logic          sd,
  output logic [AW:0]   fifo_cnt,
  output logic          overrun,
  output logic          underrun
);

  localparam int DEPTH = 1 << AW;
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW    = $clog2(2 * W);

  logic [DW-1:0]    dcnt;
  logic [BW-1:0]    bcnt;
  logic [BW-1:0]    bcnt_nx;
  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [W-1:0]     last;
  logic [2*W-1:0]   shreg;
  logic [W-1:0]     head;
  logic [W-1:0]     frame_word;
  logic             div_end;
  logic             fall_tick;
  logic             load;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_ok;

  // Divider, slot sequencing and FIFO decisions; the pop is judged on pre-cycle occupancy
  always_comb begin
    div_end    = (dcnt == DW'(DIV - 1));
    fall_tick  = div_end & sck;
    bcnt_nx    = (bcnt == BW'(2 * W - 1)) ? '0 : bcnt + 1'b1;
    load       = fall_tick & (bcnt_nx == BW'(1));
    empty      = (fifo_cnt == '0);
    full       = (fifo_cnt == (AW+1)'(DEPTH));
    pop        = load & ~empty;
    push_ok    = sample_vld & (~full | pop);
    head       = mem[rd_ptr];
    frame_word = mute ? '0 : (empty ? last : head);
  end

  // Bit clock generation: sck toggles every DIV clk cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= '0;
      sck  <= 1'b0;
    end else begin
      dcnt <= div_end ? '0 : dcnt + 1'b1;
      if (div_end) sck <= ~sck;
    end
  end

  // Slot counter, word select and serial data all move on the sck falling tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      ws    <= 1'b0;
      sd    <= 1'b0;
      shreg <= '0;
    end else if (fall_tick) begin
      bcnt <= bcnt_nx;
      ws   <= (bcnt_nx >= BW'(W));
      if (load) begin
        shreg <= {frame_word, frame_word};
        sd    <= frame_word[W-1];
      end else begin
        shreg <= {shreg[2*W-2:0], 1'b0};
        sd    <= shreg[2*W-2];
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= sample;
  end

  // FIFO pointers, occupancy and the repeat-on-empty sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      last     <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= head;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sticky error flags; a set event outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= (sample_vld & full & ~pop) | (overrun & ~clr);
      underrun <= (load & empty) | (underrun & ~clr);
    end
  end

endmodule

// File: doc/jtopl_i2s_tx.md
# jtopl_i2s_tx

Consumer end of the OPL mixed-sample path. Takes each saturated mono sample produced by the channel accumulator, buffers it in a small FIFO, and serialises it as a standard I2S stereo stream with the same sample on both channels. Runs in the `clk` domain and generates `sck` by division. Bridges the accumulator's sample cadence to a fixed-rate DAC frame, with sticky overrun/underrun reporting.

## Interface

- `W`, 16: sample width, and the bits per I2S channel slot.
- `DIV`, 4: `clk` cycles per `sck` half-period. Must be ≥1.
- `AW`, 2: FIFO address width. Depth is 2^AW.

- `clk`  in  1: system clock. One clock only; every register is in this domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sample`  in  W: signed two's-complement sample. This is the accumulator's `snd`.
- `sample_vld`  in  1: one-cycle push strobe. Driven with the registered `cenop & zero`, so it is high on the cycle after `snd` updates.
- `mute`  in  1: when high, frames carry zeros. The FIFO still pops normally.
- `clr`  in  1: synchronous clear of `overrun` and `underrun`.
- `sck`  out  1: I2S bit clock.
- `ws`  out  1: word select. 0 = left, 1 = right.
- `sd`  out  1: serial data, MSB first.
- `fifo_cnt`  out  AW+1: current FIFO occupancy, 0..2^AW.
- `overrun`  out  1: sticky; a push was dropped.
- `underrun`  out  1: sticky; a frame started with the FIFO empty.

## Operation

- **Reset values** (all registers, asynchronous on `rst_n`=0):
  - `sck`=0, `ws`=0, `sd`=0.
  - `dcnt`=0, `bcnt`=0.
  - FIFO empty, so `fifo_cnt`=0.
  - `last`=0.
  - `overrun`=0, `underrun`=0.
  - The shift register is all zeros.
- **Divider:**
  - `dcnt` counts 0..DIV-1 and wraps.
  - At `dcnt`==DIV-1, `sck` toggles.
  - The toggle 1→0 is the *fall tick*, a one-cycle internal strobe.
- **Bit slot counter:**
  - `bcnt` covers 0..2W-1.
  - It increments on each fall tick and wraps from 2W-1 to 0.
  - `ws` is registered as (`next bcnt` ≥ W). So `ws`=0 in slots 0..W-1 and 1 in slots W..2W-1.
  - `ws` therefore leads each channel's MSB by one slot, per standard I2S.
- **Frame load:**
  - On the fall tick that enters slot 1, the 2W-bit shift register loads {F,F}.
  - F is the popped sample, or `last` if the FIFO is empty, or 0 if `mute`=1.
  - `sd` presents the MSB in that slot.
  - Every other fall tick shifts left by one, and `sd` takes the new MSB.
  - Result: left MSB in slot 1, right MSB in slot W+1, right LSB in slot 0 of the next frame.
- **Pop:** occurs only at frame load.
  - Non-empty FIFO: read the head, and `last` ← head.
  - Empty FIFO: repeat `last` and set `underrun`=1.
- **Push** on `sample_vld`:
  - If the FIFO is not full, write `sample`.
  - If full, drop `sample` and set `overrun`=1.
- **Push and pop in the same cycle:**
  - The pop is evaluated first, against the pre-cycle occupancy.
  - Full FIFO: pop frees a slot, the push is accepted, no overrun, and `fifo_cnt` is unchanged.
  - Empty FIFO: the pop underruns and repeats `last`, the push is stored, and `fifo_cnt` becomes 1.
- **Flags:**
  - `clr` clears both flags.
  - If a set event coincides with `clr`, the set wins.
- **Arithmetic:**
  - Samples are passed bit-exact; there is no rescaling.
  - Pointers are AW bits and wrap modulo 2^AW. The count is AW+1 bits.

## Timing

- **First fall tick:** 2·DIV cycles after `rst_n` deasserts, which enters slot 1 and performs the first load.
- **Frame period:** 4·W·DIV `clk` cycles, i.e. 256 for the defaults.
- **Output timing:**
  - `sd` and `ws` change only in the same cycle that `sck` falls. They are stable across the rising edge.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- **FIFO latency:**
  - `fifo_cnt` reflects a push one cycle after `sample_vld`.
  - A sample pushed at least one cycle before a load tick is transmitted in that frame.
- **Reset mid-frame:**
  - All state returns to reset values immediately. FIFO contents are discarded.
  - The frame restarts from slot 0 after release.
- **`mute` and `clr`:**
  - `mute` is sampled only at the load tick, so a toggle never corrupts a partial frame.
  - `clr` acts on the next edge.

## Test plan

- **Basic frame:** reset, push 0x8001 once, capture a frame → left and right slots each decode 0x8001. `ws` falls one `sck` before the left MSB. `underrun`=0.
- **Underrun:**
  - Push 0x1234, let 3 frames pass with no pushes.
  - Frames 2 and 3 repeat 0x1234, and `underrun`=1 after the load of frame 2.
  - Then `clr`=1 → `underrun`=0.
- **Overrun:** push 5 samples on consecutive cycles with no load in between (AW=2) → `fifo_cnt`=4, `overrun`=1, 5th sample absent from later frames.
- **Simultaneous push/pop at full:** align a push with a load tick while `fifo_cnt`=4 → `overrun` stays 0 and `fifo_cnt` stays 4.
- **Mute:**
  - Assert `mute` mid-frame with 0x7FFF queued.
  - The current frame completes unchanged. The next frame is all zeros and still pops, so `fifo_cnt` decrements.
- **Reset mid-frame and DIV=1:**
  - Assert `rst_n`=0 at slot 9 → `sck`, `ws`, `sd`, and `fifo_cnt` all read 0 asynchronously.
  - With DIV=1, the frame period equals 64 cycles.
